zipalu_wb: RTL and testbench
============================

ZIPALU_WB -- requirements
Module: zipalu_wb

Interface
REQ-001 The module SHALL use parameter DEPTH, default 2, as the result-buffer entry count (legal values 2 or 4).
REQ-002 The module SHALL use parameter CC_RESET, default 4'h0, as the reset value of the condition-code register.
REQ-003 Port i_clk, input, 1 bit: the single clock; every state element SHALL be clocked on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port i_valid, input, 1 bit: ALU result valid.
REQ-006 Port o_ready, output, 1 bit: buffer can accept a result.
REQ-007 Port i_c, input, 32 bits: ALU result.
REQ-008 Port i_f, input, 4 bits: ALU flags, ordered {V,N,C,Z}.
REQ-009 Port i_illegal, input, 1 bit: ALU illegal-op indication.
REQ-010 Port i_dreg, input, 5 bits: destination register index.
REQ-011 Port i_wr_reg, input, 1 bit: write the register file on commit.
REQ-012 Port i_wr_flags, input, 1 bit: update CC on commit (clear for MOV/LDI/ROL/LODI).
REQ-013 Port i_cond, input, 3 bits: condition code (0 ALWAYS, 1 Z, 2 NE, 3 GT, 4 GE, 5 C, 6 LT, 7 V).
REQ-014 Port i_stall, input, 1 bit: register-file write port busy.
REQ-015 Port o_wr_en, output, 1 bit: register-file write strobe.
REQ-016 Port o_wr_reg, output, 5 bits: register-file write index.
REQ-017 Port o_wr_data, output, 32 bits: register-file write data.
REQ-018 Port o_cc, output, 4 bits: condition-code register, ordered {V,N,C,Z}.
REQ-019 Port o_halted, output, 1 bit: illegal-op halt state.
REQ-020 Port i_clear_halt, input, 1 bit: leave the HALTED state.

Function
REQ-021 A result SHALL be accepted on a rising edge with i_valid && o_ready; an accepted entry SHALL be at the buffer head on the next cycle (latency 1 from accept to o_wr_en).
REQ-022 o_ready SHALL be high iff the buffer is not full and the state is RUN; i_valid while !o_ready SHALL be dropped and flagged by a bench assertion.
REQ-023 The condition SHALL be evaluated against the current o_cc: GT = !N&&!Z, GE = !N, LT = N.
REQ-024 o_wr_en SHALL be combinational: head valid && RUN && i_wr_reg && condition true && !head.illegal.
REQ-025 The head SHALL retire on an edge when it is valid and either !i_stall or o_wr_en is low; a false-condition entry SHALL retire with no register or CC write.
REQ-026 On retire with the condition true and i_wr_flags set, o_cc SHALL load the head flags; otherwise o_cc SHALL hold.
REQ-027 Simultaneous accept and retire SHALL keep the occupancy unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-028 The state machine SHALL have states RUN and HALTED. Retire of an illegal head SHALL go RUN->HALTED, flush the buffer, and suppress all writes. i_clear_halt while HALTED SHALL go HALTED->RUN on the next edge; i_clear_halt while RUN SHALL be ignored.
REQ-029 o_halted SHALL be high iff the state is HALTED.

Reset
REQ-030 Asserting i_rst SHALL immediately clear the buffer, select RUN, and set o_cc=CC_RESET, o_wr_en=0, o_ready=1 after release, o_halted=0; entries in flight SHALL be discarded.

Configuration
REQ-031 With macro ZIPALU_WB_FWD_EN defined, ports o_fwd_valid (1), o_fwd_reg (5) and o_fwd_data (32) SHALL expose the youngest pending write-enabled entry for operand forwarding.
REQ-032 With ZIPALU_WB_FWD_EN undefined, these ports and their logic SHALL be absent.

Structure
REQ-033 Package zipcpu_pkg SHALL hold the condition-code enumeration, the flag bit positions (V=3, N=2, C=1, Z=0) and the state typedef.
REQ-034 Sub-module zipalu_wb_fifo SHALL implement the buffer (DEPTH entries, {c,f,illegal,dreg,wr_reg,wr_flags,cond}).

Verification
REQ-035 Accept i_c=32'h1234, i_dreg=3, i_cond=0, i_wr_flags=1, i_f=4'h4 -> next cycle o_wr_en=1, o_wr_reg=3, o_wr_data=32'h1234; o_cc=4'h4 afterwards.
REQ-036 With o_cc Z=1, accept i_cond=2 (NE) -> entry retires, o_wr_en stays 0, o_cc unchanged.
REQ-037 Hold i_stall=1 and push 3 results with DEPTH=2 -> o_ready=0 after 2 accepts; releasing the stall retires the entries in order.
REQ-038 Push an illegal result followed by a valid one -> no write occurs, o_halted=1, the buffer is empty; i_clear_halt -> o_halted=0 on the next cycle.
REQ-039 Assert i_rst mid-stall with 2 entries -> o_wr_en=0 and o_cc=CC_RESET immediately; o_ready=1 after release.

Source files
------------

// File: rtl/zipcpu_pkg.sv
// rtl/zipcpu_pkg.sv - shared types for the ALU write-back stage
package zipcpu_pkg;

  // Flag bit positions within a {V,N,C,Z} nibble
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NE     = 3'd2,
    COND_GT     = 3'd3,
    COND_GE     = 3'd4,
    COND_C      = 3'd5,
    COND_LT     = 3'd6,
    COND_V      = 3'd7
  } cond_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  f;
    logic        illegal;
    logic [4:0]  dreg;
    logic        wr_reg;
    logic        wr_flags;
    cond_e       cond;
  } wb_entry_t;

  // True when condition c holds against the committed flags cc
  function automatic logic cond_true(input cond_e c, input logic [3:0] cc);
    case (c)
      COND_ALWAYS: return 1'b1;
      COND_Z:      return cc[FLAG_Z];
      COND_NE:     return !cc[FLAG_Z];
      COND_GT:     return !cc[FLAG_N] && !cc[FLAG_Z];
      COND_GE:     return !cc[FLAG_N];
      COND_C:      return cc[FLAG_C];
      COND_LT:     return cc[FLAG_N];
      COND_V:      return cc[FLAG_V];
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/zipalu_wb_fifo.sv
// rtl/zipalu_wb_fifo.sv - result buffer; forwarding scan under ZIPALU_WB_FWD_EN
module zipalu_wb_fifo
  import zipcpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_flush,
  input  logic      i_push,
  input  wb_entry_t i_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_empty,
`ifdef ZIPALU_WB_FWD_EN
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_reg,
  output logic [31:0] o_fwd_data,
`endif
  output logic      o_full
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Pointers and occupancy; a flush empties the buffer and wins over a push
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone says what is valid
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

`ifdef ZIPALU_WB_FWD_EN
  logic [AW-1:0] w_idx;

  // Walk oldest to youngest so the youngest pending register write wins
  always_comb begin
    o_fwd_valid = 1'b0;
    o_fwd_reg   = '0;
    o_fwd_data  = '0;
    w_idx       = r_rptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + AW'(i);
      if (((AW+1)'(i) < r_count) && r_mem[w_idx].wr_reg && !r_mem[w_idx].illegal) begin
        o_fwd_valid = 1'b1;
        o_fwd_reg   = r_mem[w_idx].dreg;
        o_fwd_data  = r_mem[w_idx].c;
      end
    end
  end
`endif

endmodule

// File: rtl/zipalu_wb.sv
// rtl/zipalu_wb.sv - ALU write-back stage with CC register; ZIPALU_WB_FWD_EN adds forwarding ports
module zipalu_wb
  import zipcpu_pkg::*;
#(
  parameter int         DEPTH    = 2,
  parameter logic [3:0] CC_RESET = 4'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_c,
  input  logic [3:0]  i_f,
  input  logic        i_illegal,
  input  logic [4:0]  i_dreg,
  input  logic        i_wr_reg,
  input  logic        i_wr_flags,
  input  logic [2:0]  i_cond,
  input  logic        i_stall,
  output logic        o_wr_en,
  output logic [4:0]  o_wr_reg,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_cc,
  output logic        o_halted,
`ifdef ZIPALU_WB_FWD_EN
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_reg,
  output logic [31:0] o_fwd_data,
`endif
  input  logic        i_clear_halt
);

  state_e    r_state;
  state_e    w_state_next;
  logic [3:0] r_cc;
  wb_entry_t w_in;
  wb_entry_t w_head;
  logic      w_empty;
  logic      w_full;
  logic      w_run;
  logic      w_accept;
  logic      w_cond;
  logic      w_retire;
  logic      w_halt;

  assign w_in = '{c: i_c, f: i_f, illegal: i_illegal, dreg: i_dreg,
                  wr_reg: i_wr_reg, wr_flags: i_wr_flags, cond: cond_e'(i_cond)};

  zipalu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_halt),
    .i_push  (w_accept),
    .i_data  (w_in),
    .i_pop   (w_retire),
    .o_head  (w_head),
    .o_empty (w_empty),
`ifdef ZIPALU_WB_FWD_EN
    .o_fwd_valid (o_fwd_valid),
    .o_fwd_reg   (o_fwd_reg),
    .o_fwd_data  (o_fwd_data),
`endif
    .o_full  (w_full)
  );

  assign w_run    = (r_state == ST_RUN);
  assign o_ready  = !w_full && w_run;
  assign w_accept = i_valid && o_ready;
  assign w_cond   = cond_true(w_head.cond, r_cc);
  assign o_wr_en  = !w_empty && w_run && w_head.wr_reg && w_cond && !w_head.illegal;
  // A head that is not writing never waits on the register-file port
  assign w_retire = !w_empty && w_run && (!i_stall || !o_wr_en);
  assign w_halt   = w_retire && w_head.illegal;

  assign o_wr_reg  = w_head.dreg;
  assign o_wr_data = w_head.c;
  assign o_cc      = r_cc;
  assign o_halted  = (r_state == ST_HALTED);

  // Condition codes load only from a legal, condition-true, flag-writing retire
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cc <= CC_RESET;
    else if (w_retire && w_cond && w_head.wr_flags && !w_head.illegal)
      r_cc <= w_head.f;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // Next state: halt on illegal retire, resume on clear request
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_halt)       w_state_next = ST_HALTED;
      ST_HALTED: if (i_clear_halt) w_state_next = ST_RUN;
      default:                     w_state_next = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_zipalu_wb.sv
// tb/tb_zipalu_wb.sv - scoreboard bench for zipalu_wb
module tb_zipalu_wb;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_c = '0;
  logic [3:0]  i_f = '0;
  logic        i_illegal = 1'b0;
  logic [4:0]  i_dreg = '0;
  logic        i_wr_reg = 1'b0;
  logic        i_wr_flags = 1'b0;
  logic [2:0]  i_cond = '0;
  logic        i_stall = 1'b0;
  logic        o_wr_en;
  logic [4:0]  o_wr_reg;
  logic [31:0] o_wr_data;
  logic [3:0]  o_cc;
  logic        o_halted;
  logic        i_clear_halt = 1'b0;
`ifdef ZIPALU_WB_FWD_EN
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_reg;
  logic [31:0] o_fwd_data;
`endif

  zipalu_wb #(.DEPTH(2), .CC_RESET(4'h0)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_c          (i_c),
    .i_f          (i_f),
    .i_illegal    (i_illegal),
    .i_dreg       (i_dreg),
    .i_wr_reg     (i_wr_reg),
    .i_wr_flags   (i_wr_flags),
    .i_cond       (i_cond),
    .i_stall      (i_stall),
    .o_wr_en      (o_wr_en),
    .o_wr_reg     (o_wr_reg),
    .o_wr_data    (o_wr_data),
    .o_cc         (o_cc),
    .o_halted     (o_halted),
`ifdef ZIPALU_WB_FWD_EN
    .o_fwd_valid  (o_fwd_valid),
    .o_fwd_reg    (o_fwd_reg),
    .o_fwd_data   (o_fwd_data),
`endif
    .i_clear_halt (i_clear_halt)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_drop = 0;
  logic [3:0]  m_cc = 4'h0;
  logic        m_halt = 1'b0;
  logic [36:0] sb [$];
  logic [36:0] sb_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic m_cond(input logic [2:0] cd, input logic [3:0] cc);
    case (cd)
      3'd0:    return 1'b1;
      3'd1:    return cc[0];
      3'd2:    return !cc[0];
      3'd3:    return !cc[2] && !cc[0];
      3'd4:    return !cc[2];
      3'd5:    return cc[1];
      3'd6:    return cc[2];
      default: return cc[3];
    endcase
  endfunction

  // Drops are noted; every committed register write is matched against the scoreboard
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (i_valid && !o_ready) n_drop++;
      if (o_wr_en && !i_stall) begin
        if (sb.size() == 0) check("sb_unexpected_wr", o_wr_en, 1'b0);
        else begin
          sb_exp = sb.pop_front();
          check("sb_wr", {27'd0, o_wr_reg, o_wr_data}, {27'd0, sb_exp});
        end
      end
    end
  end

  // Called one time unit after a rising edge; returns the same offset after the next one
  task automatic push(input logic [31:0] c, input logic [3:0] f, input logic ill,
                      input logic [4:0] d, input logic wr, input logic wf, input logic [2:0] cd);
    logic acc;
    i_valid = 1'b1; i_c = c; i_f = f; i_illegal = ill; i_dreg = d;
    i_wr_reg = wr; i_wr_flags = wf; i_cond = cd;
    acc = o_ready;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    if (acc && !m_halt) begin
      if (ill) m_halt = 1'b1;
      else if (m_cond(cd, m_cc)) begin
        if (wr) sb.push_back({d, c});
        if (wf) m_cc = f;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    tick(2);
    i_rst = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_wr_en", o_wr_en, 1'b0);
    check("rst_cc", o_cc, 4'h0);
    check("rst_halted", o_halted, 1'b0);

    // Basic accept and commit
    push(32'h1234, 4'h4, 1'b0, 5'd3, 1'b1, 1'b1, 3'd0);
    check("basic_wr_en", o_wr_en, 1'b1);
    check("basic_wr_reg", o_wr_reg, 5'd3);
    check("basic_wr_data", o_wr_data, 32'h1234);
    tick(1);
    check("basic_cc", o_cc, 4'h4);

    // False condition retires silently
    push(32'h0, 4'h1, 1'b0, 5'd1, 1'b0, 1'b1, 3'd0);
    tick(1);
    check("z_cc", o_cc, 4'h1);
    push(32'hBEEF, 4'h8, 1'b0, 5'd5, 1'b1, 1'b1, 3'd2);
    check("ne_wr_en", o_wr_en, 1'b0);
    tick(1);
    check("ne_cc", o_cc, 4'h1);
    check("ne_empty", o_ready, 1'b1);

    // Random conditions and flags against the model
    for (int k = 0; k < 24; k++) begin
      push($urandom, 4'($urandom), 1'b0, 5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      tick(1);
      check("rand_cc", o_cc, m_cc);
    end

    // Clear-halt while running is ignored
    i_clear_halt = 1'b1;
    tick(1);
    i_clear_halt = 1'b0;
    check("clr_in_run", o_halted, 1'b0);

    // Stall fills the buffer; the third push is dropped
    n_drop = 0;
    i_stall = 1'b1;
    push(32'hA0, 4'h0, 1'b0, 5'd10, 1'b1, 1'b0, 3'd0);
    push(32'hA1, 4'h0, 1'b0, 5'd11, 1'b1, 1'b0, 3'd0);
    check("full_ready", o_ready, 1'b0);
    push(32'hA2, 4'h0, 1'b0, 5'd12, 1'b1, 1'b0, 3'd0);
    check("full_drop", n_drop, 1);
    check("stall_head_reg", o_wr_reg, 5'd10);
    i_stall = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick(1);
    check("stall_drain", sb.size(), 0);
    check("stall_ready", o_ready, 1'b1);

    // Illegal op halts and flushes the entry behind it
    push(32'hDEAD, 4'hF, 1'b1, 5'd7, 1'b1, 1'b1, 3'd0);
    push(32'hCAFE, 4'hF, 1'b0, 5'd8, 1'b1, 1'b1, 3'd0);
    check("halt_halted", o_halted, 1'b1);
    check("halt_wr_en", o_wr_en, 1'b0);
    check("halt_ready", o_ready, 1'b0);
    tick(2);
    check("halt_cc", o_cc, m_cc);
    check("halt_hold", o_halted, 1'b1);
    i_clear_halt = 1'b1;
    tick(1);
    i_clear_halt = 1'b0;
    m_halt = 1'b0;
    check("clr_halted", o_halted, 1'b0);
    check("clr_ready", o_ready, 1'b1);
    check("clr_wr_en", o_wr_en, 1'b0);

    // Asynchronous reset mid-stall
    push(32'h0, 4'hA, 1'b0, 5'd0, 1'b0, 1'b1, 3'd0);
    tick(1);
    check("pre_rst_cc", o_cc, 4'hA);
    i_stall = 1'b1;
    push(32'hB0, 4'h0, 1'b0, 5'd20, 1'b1, 1'b0, 3'd0);
    push(32'hB1, 4'h0, 1'b0, 5'd21, 1'b1, 1'b0, 3'd0);
    check("pre_rst_wr_en", o_wr_en, 1'b1);
    i_rst = 1'b1;
    #1;
    check("async_wr_en", o_wr_en, 1'b0);
    check("async_cc", o_cc, 4'h0);
    sb.delete();
    m_cc = 4'h0;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_stall = 1'b0;
    check("post_rst_ready", o_ready, 1'b1);
    tick(3);
    check("post_rst_wr_en", o_wr_en, 1'b0);
    check("post_rst_cc", o_cc, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
